// File: rtl/period_wave_gen.sv
// Square-wave generator: after aligning to a rising edge of si, emits periods of
// Diff_fre_h high cycles followed by Diff_fre_l low cycles while locked and en hold.
module period_wave_gen #(
    parameter int unsigned COUNTBW = 20,
    parameter int unsigned CYCBW   = 16
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               locked,
    input  logic [COUNTBW-1:0] Diff_fre_h,
    input  logic [COUNTBW-1:0] Diff_fre_l,
    input  logic               si,
    input  logic               en,
    output logic               so,
    output logic               active,
    output logic [CYCBW-1:0]   cycles,
    output logic               clamped
);

    typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

    state_e             state_q, state_d;
    logic               si_d;
    logic               si_rise;
    logic               run_ok;
    logic               load;
    logic               h_end, l_end;
    logic [COUNTBW-1:0] cnt_q, cnt_d;
    logic [COUNTBW-1:0] sh_h_q, sh_h_d;
    logic [COUNTBW-1:0] sh_l_q, sh_l_d;
    logic [CYCBW-1:0]   cycles_q, cycles_d;
    logic               clamped_q, clamped_d;
    logic               so_q, so_d;

    assign si_rise = si & ~si_d;
    assign run_ok  = locked & en;
    assign h_end   = (cnt_q == sh_h_q - COUNTBW'(1));
    assign l_end   = (cnt_q == sh_l_q - COUNTBW'(1));

    // State register
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a running period always completes before stopping
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (run_ok) state_d = StArm;
            StArm: begin
                if (!run_ok) begin
                    state_d = StIdle;
                end else if (si_rise) begin
                    state_d = StHigh;
                end
            end
            StHigh: if (h_end) state_d = StLow;
            StLow: begin
                if (l_end) begin
                    state_d = run_ok ? StHigh : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic; so lags the state by one register stage
    always_comb begin
        so_d   = (state_q == StHigh);
        active = (state_q == StHigh) || (state_q == StLow);
    end

    // Datapath next-state: phase counter, shadow lengths, period count, clamp flag
    always_comb begin
        load      = (state_d == StHigh) && (state_q != StHigh);
        cnt_d     = '0;
        sh_h_d    = sh_h_q;
        sh_l_d    = sh_l_q;
        cycles_d  = cycles_q;
        clamped_d = clamped_q;

        if (state_d == state_q && (state_q == StHigh || state_q == StLow)) begin
            cnt_d = cnt_q + COUNTBW'(1);
        end

        if (load) begin
            sh_h_d = (Diff_fre_h == '0) ? COUNTBW'(1) : Diff_fre_h;
            sh_l_d = (Diff_fre_l == '0) ? COUNTBW'(1) : Diff_fre_l;
            if (Diff_fre_h == '0 || Diff_fre_l == '0) begin
                clamped_d = 1'b1;
            end
        end

        if (state_q == StLow && l_end) begin
            cycles_d = cycles_q + CYCBW'(1);
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            si_d      <= 1'b0;
            cnt_q     <= '0;
            sh_h_q    <= '0;
            sh_l_q    <= '0;
            cycles_q  <= '0;
            clamped_q <= 1'b0;
            so_q      <= 1'b0;
        end else begin
            si_d      <= si;
            cnt_q     <= cnt_d;
            sh_h_q    <= sh_h_d;
            sh_l_q    <= sh_l_d;
            cycles_q  <= cycles_d;
            clamped_q <= clamped_d;
            so_q      <= so_d;
        end
    end

    assign so      = so_q;
    assign cycles  = cycles_q;
    assign clamped = clamped_q;

endmodule

// File: tb/tb_period_wave_gen.sv
// Scoreboard bench for period_wave_gen: expected so bits are queued as periods are
// requested and popped one per clock as the DUT runs.
module tb_period_wave_gen;

    localparam int unsigned COUNTBW = 20;

    logic               clk = 1'b0;
    logic               init_n;
    logic               locked;
    logic [COUNTBW-1:0] Diff_fre_h;
    logic [COUNTBW-1:0] Diff_fre_l;
    logic               si;
    logic               en;
    logic               so, active, clamped;
    logic [15:0]        cycles;
    logic               so4, active4, clamped4;
    logic [3:0]         cycles4;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  exp_q[$];

    always #5 clk = ~clk;

    period_wave_gen #(.COUNTBW(COUNTBW), .CYCBW(16)) dut (
        .clk(clk), .init_n(init_n), .locked(locked), .Diff_fre_h(Diff_fre_h),
        .Diff_fre_l(Diff_fre_l), .si(si), .en(en), .so(so), .active(active),
        .cycles(cycles), .clamped(clamped)
    );

    period_wave_gen #(.COUNTBW(COUNTBW), .CYCBW(4)) dut4 (
        .clk(clk), .init_n(init_n), .locked(locked), .Diff_fre_h(Diff_fre_h),
        .Diff_fre_l(Diff_fre_l), .si(si), .en(en), .so(so4), .active(active4),
        .cycles(cycles4), .clamped(clamped4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_period(input int h, input int l);
        repeat (h) exp_q.push_back(1'b1);
        repeat (l) exp_q.push_back(1'b0);
    endtask

    // One clock per expected bit; so is compared against the popped value
    task automatic drain(input int n);
        bit e;
        repeat (n) begin
            tick();
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("so", 32'(so), 32'(e));
            end
        end
    endtask

    // Produce a fresh si rising edge; the HIGH entry shows so=0 for one sample
    task automatic si_rise_start();
        si = 1'b0;
        tick();
        si = 1'b1;
        exp_q.push_back(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        init_n     = 1'b0;
        locked     = 1'b0;
        en         = 1'b0;
        si         = 1'b0;
        Diff_fre_h = 20'd5;
        Diff_fre_l = 20'd3;
        #12;
        check("rst_so", 32'(so), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        check("rst_clamped", 32'(clamped), 32'd0);
        tick();
        init_n = 1'b1;
        tick();
        tick();
        check("idle_active", 32'(active), 32'd0);

        // 5/3 periods after alignment
        locked = 1'b1;
        en     = 1'b1;
        tick();
        check("arm_active", 32'(active), 32'd0);
        check("arm_so", 32'(so), 32'd0);
        si = 1'b1;
        exp_q.push_back(1'b0);
        repeat (3) push_period(5, 3);
        drain(17);
        check("cyc_after2", 32'(cycles), 32'd2);
        drain(8);
        check("cyc_after3", 32'(cycles), 32'd3);
        check("run_active", 32'(active), 32'd1);
        check("run_clamped", 32'(clamped), 32'd0);

        // Mid-period input changes only affect the following period
        push_period(5, 3);
        push_period(10, 3);
        push_period(5, 3);
        drain(2);
        Diff_fre_h = 20'd10;
        drain(9);
        Diff_fre_h = 20'd5;
        drain(10);
        check("cyc_after5", 32'(cycles), 32'd5);

        // en drop in the 2nd HIGH cycle: period completes, then idle
        drain(1);
        en = 1'b0;
        drain(7);
        check("stop_cycles", 32'(cycles), 32'd6);
        check("stop_active", 32'(active), 32'd0);
        repeat (3) tick();
        check("idle_so", 32'(so), 32'd0);
        check("idle_active2", 32'(active), 32'd0);
        check("idle_cycles", 32'(cycles), 32'd6);

        // Zero lengths clamp to 1; clamped is sticky
        Diff_fre_h = 20'd0;
        Diff_fre_l = 20'd2;
        en = 1'b1;
        tick();
        si_rise_start();
        repeat (3) push_period(1, 2);
        drain(9);
        Diff_fre_h = 20'd5;
        Diff_fre_l = 20'd3;
        drain(1);
        check("clamp_set", 32'(clamped), 32'd1);
        push_period(5, 3);
        drain(8);
        check("clamp_sticky", 32'(clamped), 32'd1);
        check("clamp_cycles", 32'(cycles), 32'd10);

        // Async reset mid-LOW with cycles=7
        tick();
        init_n = 1'b0;
        tick();
        check("rst2_cycles", 32'(cycles), 32'd0);
        check("rst2_clamped", 32'(clamped), 32'd0);
        init_n     = 1'b1;
        Diff_fre_h = 20'd2;
        Diff_fre_l = 20'd2;
        tick();
        si_rise_start();
        repeat (8) push_period(2, 2);
        drain(31);
        check("pre_rst_cycles", 32'(cycles), 32'd7);
        check("pre_rst_active", 32'(active), 32'd1);
        check("pre_rst_so", 32'(so), 32'd1);
        exp_q.delete();
        #2;
        init_n = 1'b0;
        #1;
        check("async_so", 32'(so), 32'd0);
        check("async_cycles", 32'(cycles), 32'd0);
        check("async_active", 32'(active), 32'd0);
        @(posedge clk);
        #1;
        si     = 1'b1;
        en     = 1'b0;
        init_n = 1'b1;
        repeat (4) begin
            tick();
            check("post_rst_so", 32'(so), 32'd0);
            check("post_rst_active", 32'(active), 32'd0);
        end
        en = 1'b1;
        repeat (3) begin
            tick();
            check("no_rise_so", 32'(so), 32'd0);
            check("no_rise_active", 32'(active), 32'd0);
        end
        si_rise_start();
        push_period(2, 2);
        drain(5);
        check("restart_cycles", 32'(cycles), 32'd1);

        // Period counter wrap on the 4-bit instance
        tick();
        init_n = 1'b0;
        tick();
        init_n     = 1'b1;
        Diff_fre_h = 20'd1;
        Diff_fre_l = 20'd1;
        tick();
        si_rise_start();
        repeat (17) push_period(1, 1);
        drain(31);
        check("wrap_pre", 32'(cycles4), 32'd15);
        drain(4);
        check("wrap_post", 32'(cycles4), 32'd1);
        check("wide_cycles", 32'(cycles), 32'd17);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/period_wave_gen.md
PERIOD_WAVE_GEN -- requirements
Module: period_wave_gen

Interface
REQ-001 Parameter COUNTBW, default 20, width of the phase-length inputs and internal counters.
REQ-002 Parameter CYCBW, default 16, width of the completed-period counter.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 init_n  input  1  reset, asynchronous and active-low; asserting it clears all state immediately.
REQ-005 locked  input  1  high when Diff_fre_h/Diff_fre_l are valid; driven by the period measurement stage.
REQ-006 Diff_fre_h  input  COUNTBW  target high-phase length in clk cycles.
REQ-007 Diff_fre_l  input  COUNTBW  target low-phase length in clk cycles.
REQ-008 si  input  1  measured reference square wave; used only for start alignment.
REQ-009 en  input  1  generation enable.
REQ-010 so  output  1  generated square wave; registered.
REQ-011 active  output  1  high while in state HIGH or LOW.
REQ-012 cycles  output  CYCBW  count of completed so periods; wraps modulo 2^CYCBW.
REQ-013 clamped  output  1  sticky flag: a zero phase length was loaded.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ARM, HIGH, LOW.
REQ-015 si SHALL be registered once (si_d); si_rise = si & ~si_d, evaluated on the same edge.
REQ-016 IDLE -> ARM when locked=1 and en=1; otherwise stay in IDLE; so=0.
REQ-017 ARM -> HIGH on the edge where si_rise=1; ARM -> IDLE if locked=0 or en=0 on that edge; so=0 in ARM.
REQ-018 On every HIGH entry, shadow registers sh_h/sh_l SHALL load Diff_fre_h/Diff_fre_l; input changes during a period SHALL NOT affect that period.
REQ-019 A loaded value of 0 SHALL be replaced by 1 and SHALL set clamped; clamped clears only on reset.
REQ-020 so SHALL be 1 for exactly sh_h consecutive cycles in HIGH, then 0 for exactly sh_l consecutive cycles in LOW.
REQ-021 Phase counter SHALL reset to 0 on each phase entry and increment by 1 per cycle; phase ends on the edge where counter = length-1.
REQ-022 At end of LOW: cycles increments by 1; if locked=1 and en=1, go directly to HIGH with a fresh shadow load (no gap cycle); otherwise go to IDLE.
REQ-023 Deassertion of en or locked during HIGH or LOW SHALL NOT truncate the current period; the period completes, then the FSM goes to IDLE.
REQ-024 so latency: so rises on the first clk edge after the edge where si_rise is sampled in ARM.
REQ-025 active SHALL be 1 exactly while the state is HIGH or LOW.
REQ-026 cycles wraps from 2^CYCBW-1 to 0 with no flag.
REQ-027 The FSM SHALL always return through ARM before restarting from IDLE, i.e., it always re-aligns to si after a stop.

Reset
REQ-028 On init_n=0: state=IDLE, so=0, active=0, cycles=0, clamped=0, counters=0, shadows=0, si_d=0, asynchronously.
REQ-029 Reset asserted mid-HIGH SHALL drop so to 0 immediately without waiting for a clock edge.
REQ-030 After init_n deasserts, behaviour SHALL start from IDLE on the next clock edge.

Verification
REQ-031 locked=1, en=1, Diff_fre_h=5, Diff_fre_l=3, si toggling -> after first si_rise, so is 5 high / 3 low repeating, cycles +1 every 8 clk.
REQ-032 Diff_fre_h changes 5->10 in mid-HIGH -> current period stays 5/3; next period is 10/3.
REQ-033 Diff_fre_h=0, Diff_fre_l=2 -> so 1 high / 2 low, clamped=1 and stays 1 after inputs return to nonzero.
REQ-034 en drops on 2nd cycle of HIGH (h=5, l=3) -> full 5/3 period completes, cycles +1, FSM to IDLE, so=0, active=0.
REQ-035 init_n pulsed low mid-LOW with cycles=7 -> so=0, cycles=0, active=0 immediately; after release, no so activity until locked&en and a new si_rise.
REQ-036 CYCBW=4, h=1, l=1 for 17 periods -> cycles wraps 15->0 and reads 1 at the end.
